// File: rtl/adder_seq_ctrl.sv
// Multi-precision add sequencer: one BW_DATA-bit adder reused over N_WORD cycles, LSW first.
// Optional subtract mode enabled by defining ADDSEQ_SUB_EN (adds the i_sub port).

module adder_param #(
  parameter int BW = 8
) (
  input  logic [BW-1:0] i_a,
  input  logic [BW-1:0] i_b,
  input  logic          i_c,
  output logic [BW-1:0] o_s,
  output logic          o_c
);
  assign {o_c, o_s} = {1'b0, i_a} + {1'b0, i_b} + {{BW{1'b0}}, i_c};
endmodule

// state | meaning
// IDLE  | o_ready high, waiting for an operand
// RUN   | adding word[idx], one word per cycle
// DONE  | o_valid high, result held until consumer accepts
module adder_seq_ctrl #(
  parameter int  BW_DATA = 8,
  parameter int  N_WORD  = 4,
  localparam int BW_IDX  = $clog2(N_WORD)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [N_WORD*BW_DATA-1:0] i_a,
  input  logic [N_WORD*BW_DATA-1:0] i_b,
  input  logic                      i_c,
`ifdef ADDSEQ_SUB_EN
  input  logic                      i_sub,
`endif
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [N_WORD*BW_DATA-1:0] o_s,
  output logic                      o_c,
  output logic                      o_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [BW_IDX-1:0] IDX_LAST = BW_IDX'(N_WORD - 1);

  state_t state, state_nxt;

  logic [N_WORD-1:0][BW_DATA-1:0] a_q;
  logic [N_WORD-1:0][BW_DATA-1:0] b_q;
  logic [N_WORD-1:0][BW_DATA-1:0] s_q;
  logic [BW_IDX-1:0]              idx;
  logic                           carry_q;
  logic                           c_q;
  logic                           accept;
  logic                           last;
  logic                           cin_load;
  logic [BW_DATA-1:0]             b_word;
  logic [BW_DATA-1:0]             add_s;
  logic                           add_c;

`ifdef ADDSEQ_SUB_EN
  logic sub_q;
  // Subtract as A + ~B + 1: invert every B word and the incoming carry.
  assign b_word   = sub_q ? ~b_q[idx] : b_q[idx];
  assign cin_load = i_sub ? ~i_c : i_c;
`else
  assign b_word   = b_q[idx];
  assign cin_load = i_c;
`endif

  adder_param #(.BW(BW_DATA)) u_add (
    .i_a (a_q[idx]),
    .i_b (b_word),
    .i_c (carry_q),
    .o_s (add_s),
    .o_c (add_c)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    o_ready   = 1'b0;
    o_valid   = 1'b0;
    o_busy    = 1'b0;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        o_busy = 1'b1;
        if (idx == IDX_LAST) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        o_busy  = 1'b1;
        o_valid = 1'b1;
        if (i_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      idx     <= '0;
      carry_q <= 1'b0;
      c_q     <= 1'b0;
`ifdef ADDSEQ_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else if (accept) begin
      a_q     <= i_a;
      b_q     <= i_b;
      carry_q <= cin_load;
      idx     <= '0;
`ifdef ADDSEQ_SUB_EN
      sub_q   <= i_sub;
`endif
    end else if (state == RUN) begin
      s_q[idx] <= add_s;
      carry_q  <= add_c;
      if (last) begin
        c_q <= add_c;
        idx <= '0;
      end else begin
        idx <= idx + BW_IDX'(1);
      end
    end
  end

  assign o_s = s_q;
  assign o_c = c_q;

endmodule
